// File: rtl/rv32_pkg.sv
// Shared register-file constants, scheduler FSM states and a saturating counter helper.
package rv32_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned XLEN       = 32;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StWaiting  = 2'd1,
      StThrottle = 2'd2
   } sched_state_e;

   function automatic logic [31:0] sat_inc32(input logic [31:0] val);
      return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/rf_pending_scoreboard.sv
// Per-register pending bits for long-latency results plus an in-flight counter.
// Set and clear may hit the same cycle; the counter then holds and never underflows.
module rf_pending_scoreboard
   import rv32_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_addr,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_addr,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   output logic                  rs1_pending,
   output logic                  rs2_pending,
   output logic                  rd_pending,
   output logic                  full,
   output logic [CNT_W-1:0]      outstanding
);

   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic [CNT_W-1:0]    count_q, count_d;

   always_comb begin
      pending_d = pending_q;
      if (clr_en) pending_d[clr_addr] = 1'b0;
      if (set_en) pending_d[set_addr] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_comb begin
      count_d = count_q;
      if (set_en && !clr_en) begin
         count_d = count_q + CNT_W'(1);
      end else if (!set_en && clr_en && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_q <= '0;
         count_q   <= '0;
      end else begin
         pending_q <= pending_d;
         count_q   <= count_d;
      end
   end

   assign rs1_pending = pending_q[rs1_addr];
   assign rs2_pending = pending_q[rs2_addr];
   assign rd_pending  = pending_q[rd_addr];
   assign full        = (count_q == CNT_W'(MAX_OUTSTANDING));
   assign outstanding = count_q;

endmodule

// File: rtl/rf_writeback_scheduler.sv
// Register-file write-port arbiter (WB over long-latency), RAW/WAW/FULL issue stall and
// long-latency starvation throttle. Optional stall/throttle counters under RF_WB_STATS_EN.
module rf_writeback_scheduler
   import rv32_pkg::*;
#(
   parameter int unsigned XLEN            = 32,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned STARVE_LIMIT    = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid_i,
   input  logic                  id_flush_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
   input  logic                  id_rs1_used_i,
   input  logic                  id_rs2_used_i,
   input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
   input  logic                  id_reg_write_i,
   input  logic                  id_long_lat_i,
   output logic                  stall_o,
   input  logic                  wb_reg_write_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
   input  logic [XLEN-1:0]       wb_data_i,
   input  logic                  ll_valid_i,
   input  logic [REG_ADDR_W-1:0] ll_rd_addr_i,
   input  logic [XLEN-1:0]       ll_data_i,
   output logic                  ll_ready_o,
   output logic                  rf_wen_o,
   output logic [REG_ADDR_W-1:0] rf_waddr_o,
   output logic [XLEN-1:0]       rf_wdata_o,
   output logic [31:0]           stat_stall_o,
   output logic [31:0]           stat_starve_o
);

   localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

   sched_state_e      state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              active_q;
   logic              en;
   logic              wb_win;
   logic              ll_xfer;
   logic              hazard;
   logic              issue;
   logic              set_en;
   logic              rs1_pending, rs2_pending, rd_pending, full;
   logic [CNT_W-1:0]  outstanding;

   // Outputs stay quiet during reset and for the first cycle after it.
   assign en = rst_n && active_q;

   assign wb_win     = wb_reg_write_i && (wb_rd_addr_i != '0);
   assign ll_ready_o = en && ll_valid_i && !wb_win;
   assign ll_xfer    = ll_valid_i && ll_ready_o;

   always_comb begin
      rf_wen_o   = 1'b0;
      rf_waddr_o = '0;
      rf_wdata_o = '0;
      if (en && wb_win) begin
         rf_wen_o   = 1'b1;
         rf_waddr_o = wb_rd_addr_i;
         rf_wdata_o = wb_data_i;
      end else if (ll_ready_o) begin
         rf_wen_o   = (ll_rd_addr_i != '0);
         rf_waddr_o = ll_rd_addr_i;
         rf_wdata_o = ll_data_i;
      end
   end

   assign hazard = (id_rs1_used_i && (id_rs1_addr_i != '0) && rs1_pending)
                 | (id_rs2_used_i && (id_rs2_addr_i != '0) && rs2_pending)
                 | (id_reg_write_i && (id_rd_addr_i != '0) && rd_pending)
                 | (id_long_lat_i && full)
                 | (state_q == StThrottle);

   assign stall_o = en && id_valid_i && !id_flush_i && hazard;
   assign issue   = en && id_valid_i && !id_flush_i && !stall_o;
   assign set_en  = issue && id_long_lat_i && id_reg_write_i && (id_rd_addr_i != '0);

   rf_pending_scoreboard #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W)
   ) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .set_en      (set_en),
      .set_addr    (id_rd_addr_i),
      .clr_en      (ll_xfer),
      .clr_addr    (ll_rd_addr_i),
      .rs1_addr    (id_rs1_addr_i),
      .rs2_addr    (id_rs2_addr_i),
      .rd_addr     (id_rd_addr_i),
      .rs1_pending (rs1_pending),
      .rs2_pending (rs2_pending),
      .rd_pending  (rd_pending),
      .full        (full),
      .outstanding (outstanding)
   );

   // A dropped ll_valid without transfer is a protocol error; just fall back to idle.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      unique case (state_q)
         StIdle: begin
            if (en && ll_valid_i && !ll_ready_o) begin
               state_d = StWaiting;
               wait_d  = WAIT_W'(1);
            end
         end
         StWaiting: begin
            if (ll_xfer || !ll_valid_i) begin
               state_d = StIdle;
               wait_d  = '0;
            end else if (wait_q == WAIT_W'(STARVE_LIMIT)) begin
               state_d = StThrottle;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         StThrottle: begin
            if (ll_xfer || !ll_valid_i) begin
               state_d = StIdle;
               wait_d  = '0;
            end
         end
         default: begin
            state_d = StIdle;
            wait_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         state_q  <= StIdle;
         wait_q   <= '0;
      end else begin
         active_q <= 1'b1;
         state_q  <= state_d;
         wait_q   <= wait_d;
      end
   end

`ifdef RF_WB_STATS_EN
   logic [31:0] stat_stall_q, stat_starve_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_stall_q  <= '0;
         stat_starve_q <= '0;
      end else begin
         if (stall_o) stat_stall_q <= sat_inc32(stat_stall_q);
         if (state_q == StThrottle) stat_starve_q <= sat_inc32(stat_starve_q);
      end
   end

   assign stat_stall_o  = stat_stall_q;
   assign stat_starve_o = stat_starve_q;
`else
   assign stat_stall_o  = '0;
   assign stat_starve_o = '0;
`endif

   logic unused_outstanding;
   assign unused_outstanding = ^outstanding;

endmodule

// File: tb/tb_rf_writeback_scheduler.sv
// Directed bench for rf_writeback_scheduler: reset, arbitration, RAW/WAW/FULL stalls, x0, throttle.
module tb_rf_writeback_scheduler;

   logic        clk;
   logic        rst_n;
   logic        id_valid, id_flush;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic        id_rs1_used, id_rs2_used, id_reg_write, id_long_lat;
   logic        stall;
   logic        wb_reg_write;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_data;
   logic        ll_valid;
   logic [4:0]  ll_rd_addr;
   logic [31:0] ll_data;
   logic        ll_ready;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] stat_stall, stat_starve;

   int checks   = 0;
   int failures = 0;

   rf_writeback_scheduler #(
      .XLEN            (32),
      .MAX_OUTSTANDING (4),
      .STARVE_LIMIT    (8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_valid_i     (id_valid),
      .id_flush_i     (id_flush),
      .id_rs1_addr_i  (id_rs1_addr),
      .id_rs2_addr_i  (id_rs2_addr),
      .id_rs1_used_i  (id_rs1_used),
      .id_rs2_used_i  (id_rs2_used),
      .id_rd_addr_i   (id_rd_addr),
      .id_reg_write_i (id_reg_write),
      .id_long_lat_i  (id_long_lat),
      .stall_o        (stall),
      .wb_reg_write_i (wb_reg_write),
      .wb_rd_addr_i   (wb_rd_addr),
      .wb_data_i      (wb_data),
      .ll_valid_i     (ll_valid),
      .ll_rd_addr_i   (ll_rd_addr),
      .ll_data_i      (ll_data),
      .ll_ready_o     (ll_ready),
      .rf_wen_o       (rf_wen),
      .rf_waddr_o     (rf_waddr),
      .rf_wdata_o     (rf_wdata),
      .stat_stall_o   (stat_stall),
      .stat_starve_o  (stat_starve)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic ll);
      id_valid     = v;
      id_flush     = 1'b0;
      id_rs1_addr  = rs1;
      id_rs1_used  = u1;
      id_rs2_addr  = rs2;
      id_rs2_used  = u2;
      id_rd_addr   = rd;
      id_reg_write = rw;
      id_long_lat  = ll;
   endtask

   task automatic idle();
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      wb_reg_write = 1'b0;
      wb_rd_addr   = 5'd0;
      wb_data      = 32'd0;
      ll_valid     = 1'b0;
      ll_rd_addr   = 5'd0;
      ll_data      = 32'd0;
   endtask

   task automatic ll_put(input logic [4:0] rd, input logic [31:0] data);
      ll_valid   = 1'b1;
      ll_rd_addr = rd;
      ll_data    = data;
   endtask

   task automatic wb_put(input logic [4:0] rd, input logic [31:0] data);
      wb_reg_write = 1'b1;
      wb_rd_addr   = rd;
      wb_data      = data;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      tick();
      tick();

      // Reset: outputs quiet even with active inputs.
      wb_put(5'd7, 32'h1);
      ll_put(5'd5, 32'h2);
      set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
      #1;
      check("rst_wen", rf_wen, 0);
      check("rst_ready", ll_ready, 0);
      check("rst_stall", stall, 0);
      check("rst_stat_stall", stat_stall, 0);
      check("rst_stat_starve", stat_starve, 0);
      tick();
      idle();
      rst_n = 1'b1;
      wb_put(5'd7, 32'h1);
      #1;
      check("post_rst_wen", rf_wen, 0);
      tick();
      check("wb_wen", rf_wen, 1);
      check("wb_waddr", rf_waddr, 7);
      idle();

      // Arbitration: WB beats long-latency, which lands the next free cycle.
      wb_put(5'd7, 32'h11);
      ll_put(5'd5, 32'h22);
      #1;
      check("arb_wen", rf_wen, 1);
      check("arb_waddr", rf_waddr, 7);
      check("arb_wdata", rf_wdata, 32'h11);
      check("arb_ll_ready", ll_ready, 0);
      tick();
      wb_reg_write = 1'b0;
      #1;
      check("arb_ll_wen", rf_wen, 1);
      check("arb_ll_waddr", rf_waddr, 5);
      check("arb_ll_wdata", rf_wdata, 32'h22);
      check("arb_ll_ready2", ll_ready, 1);
      tick();
      idle();

      // RAW on a pending DIV result.
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1);
      #1;
      check("raw_div_issue", stall, 0);
      tick();
      set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
      #1;
      check("raw_stall", stall, 1);
      tick();
      check("raw_stall_hold", stall, 1);
      ll_put(5'd5, 32'h55);
      #1;
      check("raw_stall_on_xfer", stall, 1);
      check("raw_xfer_ready", ll_ready, 1);
      tick();
      ll_valid = 1'b0;
      #1;
      check("raw_release", stall, 0);
      tick();
      idle();

      // x0 destinations never become pending.
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
      #1;
      check("x0_div_issue", stall, 0);
      tick();
      set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
      #1;
      check("x0_add_nostall", stall, 0);
      tick();
      idle();
      ll_put(5'd0, 32'h99);
      #1;
      check("x0_ll_wen", rf_wen, 0);
      check("x0_ll_ready", ll_ready, 1);
      tick();
      idle();

      // FULL: four DIVs in flight block a fifth until one completes.
      for (int i = 1; i <= 4; i++) begin
         set_id(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'(i), 1'b1, 1'b1);
         #1;
         check("full_fill_issue", stall, 0);
         tick();
      end
      set_id(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'd8, 1'b1, 1'b1);
      #1;
      check("full_stall", stall, 1);
      tick();
      ll_put(5'd1, 32'h1234);
      #1;
      check("full_stall_on_xfer", stall, 1);
      tick();
      ll_valid = 1'b0;
      #1;
      check("full_fifth_issues", stall, 0);
      tick();
      set_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
      #1;
      check("raw_x8", stall, 1);
      id_flush = 1'b1;
      #1;
      check("flush_no_stall", stall, 0);
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
      #1;
      check("waw_x3", stall, 1);
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1);
      #1;
      check("full_again", stall, 1);
      idle();

      // Reset clears a non-empty scoreboard.
      ll_put(5'd2, 32'h2);
      tick();
      ll_put(5'd3, 32'h3);
      tick();
      idle();
      set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
      #1;
      check("pre_rst_raw_x4", stall, 1);
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      set_id(1'b1, 5'd4, 1'b1, 5'd8, 1'b1, 5'd4, 1'b1, 1'b1);
      #1;
      check("post_rst_no_stall", stall, 0);
      check("post_rst_stat_stall", stat_stall, 0);
      check("post_rst_stat_starve", stat_starve, 0);
      tick();
      idle();

      // Starvation: WB busy long enough to push the FSM into THROTTLE.
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0);
      wb_put(5'd7, 32'h77);
      ll_put(5'd20, 32'hAB);
      for (int c = 1; c <= 9; c++) begin
         #1;
         check("starve_wait_stall", stall, 0);
         tick();
      end
      #1;
      check("throttle_stall", stall, 1);
      check("throttle_blocked", ll_ready, 0);
      tick();
      wb_reg_write = 1'b0;
      #1;
      check("throttle_xfer_stall", stall, 1);
      check("throttle_xfer_ready", ll_ready, 1);
      check("throttle_xfer_waddr", rf_waddr, 20);
      tick();
      ll_valid = 1'b0;
      #1;
      check("throttle_released", stall, 0);
`ifdef RF_WB_STATS_EN
      check("stat_stall_count", stat_stall, 2);
      check("stat_starve_count", stat_starve, 2);
`else
      check("stat_stall_tied", stat_stall, 0);
      check("stat_starve_tied", stat_starve, 0);
`endif
      tick();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
